// File: rtl/wb_fhe_host_master.sv
// Wishbone classic initiator for the FHE accelerator slave port.
// Commands are queued in a small FIFO and each one returns exactly one response.
module wb_fhe_host_master #(
  parameter int          ADDR_WIDTH  = 9,
  parameter logic [31:0] OPCODE_ADDR = 32'h3000_0000,
  parameter int          FIFO_DEPTH  = 4,
  parameter int          TIMEOUT     = 64,
  parameter int          EXEC_WAIT   = 12
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_ni,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [1:0]            cmd_kind_i,
  input  logic [31:0]           cmd_addr_i,
  input  logic [31:0]           cmd_wdata_i,
  input  logic [1:0]            cmd_fhe_op_i,
  input  logic [ADDR_WIDTH-1:0] cmd_src_a_i,
  input  logic [ADDR_WIDTH-1:0] cmd_src_b_i,
  input  logic [ADDR_WIDTH-1:0] cmd_dst_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [31:0]           rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  wbm_cyc_o,
  output logic                  wbm_stb_o,
  output logic                  wbm_we_o,
  output logic [3:0]            wbm_sel_o,
  output logic [31:0]           wbm_adr_o,
  output logic [31:0]           wbm_dat_o,
  input  logic [31:0]           wbm_dat_i,
  input  logic                  wbm_ack_i,
  output logic                  busy_o
);
  // state | meaning
  // IDLE  | waiting for a queued command; pops and launches the bus cycle
  // BUS   | cyc/stb asserted, waiting for ack or timeout
  // WAIT  | EXEC accepted, letting the accelerator compute
  // RESP  | response presented until rsp_ready_i
  typedef enum logic [1:0] {ST_IDLE, ST_BUS, ST_WAIT, ST_RESP} state_t;

  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CMAX = (TIMEOUT > EXEC_WAIT) ? TIMEOUT : EXEC_WAIT;
  localparam int TW   = $clog2(CMAX + 1);

  typedef struct packed {
    logic        we;
    logic        rd;
    logic        ex;
    logic [31:0] adr;
    logic [31:0] dat;
  } entry_t;

  entry_t          mem_q [FIFO_DEPTH];
  entry_t          push_ent, head_ent;
  logic [31:0]     exec_word;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]     count_q, count_d;
  logic            ready_q, ready_d;
  logic            push, pop;

  state_t          state_q, state_d;
  logic            cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [3:0]      sel_q, sel_d;
  logic [31:0]     adr_q, adr_d, dat_q, dat_d;
  logic            rd_q, rd_d, ex_q, ex_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic            rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [31:0]     rsp_rdata_q, rsp_rdata_d;

  // Bus address/data are resolved at push time so the FSM only replays them.
  always_comb begin
    exec_word = '0;
    exec_word[1:0] = cmd_fhe_op_i;
    exec_word[ADDR_WIDTH+1:2] = cmd_src_a_i;
    exec_word[2*ADDR_WIDTH+1:ADDR_WIDTH+2] = cmd_src_b_i;
    exec_word[3*ADDR_WIDTH+1:2*ADDR_WIDTH+2] = cmd_dst_i;
    exec_word[31] = 1'b1;
    push_ent = '0;
    push_ent.adr = cmd_addr_i;
    push_ent.dat = cmd_wdata_i;
    case (cmd_kind_i)
      2'b00: push_ent.we = 1'b1;
      2'b10: begin
        push_ent.we  = 1'b1;
        push_ent.ex  = 1'b1;
        push_ent.adr = OPCODE_ADDR;
        push_ent.dat = exec_word;
      end
      default: push_ent.rd = 1'b1;
    endcase
  end

  assign head_ent = mem_q[rd_ptr_q];
  assign push     = cmd_valid_i & ready_q;
  assign pop      = (state_q == ST_IDLE) && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + (PW+1)'(push) - (PW+1)'(pop);
    ready_d  = (count_d != (PW+1)'(FIFO_DEPTH));
  end

  always_ff @(posedge wb_clk_i) begin
    if (push) mem_q[wr_ptr_q] <= push_ent;
  end

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    rd_d        = rd_q;
    ex_d        = ex_q;
    tmr_d       = tmr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          state_d = ST_BUS;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = head_ent.we;
          sel_d   = 4'hF;
          adr_d   = head_ent.adr;
          dat_d   = head_ent.dat;
          rd_d    = head_ent.rd;
          ex_d    = head_ent.ex;
          tmr_d   = TW'(TIMEOUT - 1);
        end
      end
      ST_BUS: begin
        if (wbm_ack_i || tmr_q == '0) begin
          cyc_d = 1'b0;
          stb_d = 1'b0;
          we_d  = 1'b0;
          sel_d = 4'h0;
          adr_d = '0;
          dat_d = '0;
          // An ack on the terminal-count cycle still wins over the timeout.
          if (wbm_ack_i) begin
            rsp_rdata_d = rd_q ? wbm_dat_i : 32'h0;
            rsp_err_d   = 1'b0;
            if (ex_q && EXEC_WAIT > 0) begin
              state_d = ST_WAIT;
              tmr_d   = TW'(EXEC_WAIT - 1);
            end else begin
              state_d     = ST_RESP;
              rsp_valid_d = 1'b1;
            end
          end else begin
            rsp_rdata_d = 32'h0;
            rsp_err_d   = 1'b1;
            rsp_valid_d = 1'b1;
            state_d     = ST_RESP;
          end
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      ST_WAIT: begin
        if (tmr_q == '0) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = 32'h0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ready_q     <= 1'b0;
      state_q     <= ST_IDLE;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= 4'h0;
      adr_q       <= '0;
      dat_q       <= '0;
      rd_q        <= 1'b0;
      ex_q        <= 1'b0;
      tmr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ready_q     <= ready_d;
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      rd_q        <= rd_d;
      ex_q        <= ex_d;
      tmr_q       <= tmr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign cmd_ready_o = ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = stb_q;
  assign wbm_we_o    = we_q;
  assign wbm_sel_o   = sel_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = dat_q;
  assign busy_o      = (state_q != ST_IDLE) || (count_q != '0);

endmodule

// File: tb/tb_wb_fhe_host_master.sv
// Directed bench for wb_fhe_host_master: writes, EXEC packing/latency, reads,
// FIFO backpressure, bus timeout and mid-transaction reset.
module tb_wb_fhe_host_master;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready_o;
  logic [1:0]  cmd_kind;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [1:0]  cmd_op;
  logic [8:0]  cmd_a, cmd_b, cmd_d;
  logic        rsp_valid_o, rsp_ready, rsp_err_o;
  logic [31:0] rsp_rdata_o;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic        wbm_ack_i;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  wb_fhe_host_master dut (
    .wb_clk_i    (clk),
    .wb_rst_ni   (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready_o),
    .cmd_kind_i  (cmd_kind),
    .cmd_addr_i  (cmd_addr),
    .cmd_wdata_i (cmd_wdata),
    .cmd_fhe_op_i(cmd_op),
    .cmd_src_a_i (cmd_a),
    .cmd_src_b_i (cmd_b),
    .cmd_dst_i   (cmd_d),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_err_o   (rsp_err_o),
    .wbm_cyc_o   (wbm_cyc_o),
    .wbm_stb_o   (wbm_stb_o),
    .wbm_we_o    (wbm_we_o),
    .wbm_sel_o   (wbm_sel_o),
    .wbm_adr_o   (wbm_adr_o),
    .wbm_dat_o   (wbm_dat_o),
    .wbm_dat_i   (wbm_dat_i),
    .wbm_ack_i   (wbm_ack_i),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_cmd(input logic [1:0] kind, input logic [31:0] adr, input logic [31:0] wd,
                          input logic [1:0] op, input logic [8:0] a, input logic [8:0] b,
                          input logic [8:0] d);
    int n;
    cmd_kind = kind; cmd_addr = adr; cmd_wdata = wd;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_d = d;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready_o && n < 200) begin tick(1); n++; end
    chk("push_ready", {31'b0, cmd_ready_o}, 32'd1);
    tick(1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_cyc(input string tag);
    int n;
    n = 0;
    while (!wbm_cyc_o && n < 50) begin tick(1); n++; end
    chk({tag, "_cyc"}, {31'b0, wbm_cyc_o}, 32'd1);
  endtask

  // Acks the pending bus cycle and completes the response handshake.
  task automatic serve(input string tag, input logic [31:0] exp_adr, input logic exp_we,
                       input logic [31:0] rd, input logic [31:0] exp_rdata);
    wait_cyc(tag);
    chk({tag, "_adr"}, wbm_adr_o, exp_adr);
    chk({tag, "_we"}, {31'b0, wbm_we_o}, {31'b0, exp_we});
    wbm_dat_i = rd; wbm_ack_i = 1'b1;
    tick(1);
    wbm_ack_i = 1'b0; wbm_dat_i = 32'h0;
    chk({tag, "_valid"}, {31'b0, rsp_valid_o}, 32'd1);
    chk({tag, "_rdata"}, rsp_rdata_o, exp_rdata);
    chk({tag, "_err"}, {31'b0, rsp_err_o}, 32'd0);
    rsp_ready = 1'b1;
    tick(1);
    rsp_ready = 1'b0;
    chk({tag, "_valid_drop"}, {31'b0, rsp_valid_o}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b1;
    cmd_valid = 1'b0; cmd_kind = 2'b00; cmd_addr = '0; cmd_wdata = '0;
    cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_d = '0;
    rsp_ready = 1'b0; wbm_dat_i = '0; wbm_ack_i = 1'b0;
    #2 rst_n = 1'b0;
    tick(2);
    chk("rst_cyc", {31'b0, wbm_cyc_o}, 32'd0);
    chk("rst_stb", {31'b0, wbm_stb_o}, 32'd0);
    chk("rst_we", {31'b0, wbm_we_o}, 32'd0);
    chk("rst_sel", {28'b0, wbm_sel_o}, 32'd0);
    chk("rst_adr", wbm_adr_o, 32'd0);
    chk("rst_dat", wbm_dat_o, 32'd0);
    chk("rst_valid", {31'b0, rsp_valid_o}, 32'd0);
    chk("rst_err", {31'b0, rsp_err_o}, 32'd0);
    chk("rst_rdata", rsp_rdata_o, 32'd0);
    chk("rst_ready", {31'b0, cmd_ready_o}, 32'd0);
    rst_n = 1'b1;
    tick(2);
    chk("rel_ready", {31'b0, cmd_ready_o}, 32'd1);
    chk("rel_busy", {31'b0, busy_o}, 32'd0);

    // WRITE: latency, bus fields, delayed ack
    push_cmd(2'b00, 32'h3000_0004, 32'd10, 2'b00, 9'd0, 9'd0, 9'd0);
    chk("w_cyc_early", {31'b0, wbm_cyc_o}, 32'd0);
    tick(1);
    chk("w_cyc", {31'b0, wbm_cyc_o}, 32'd1);
    chk("w_stb", {31'b0, wbm_stb_o}, 32'd1);
    chk("w_we", {31'b0, wbm_we_o}, 32'd1);
    chk("w_adr", wbm_adr_o, 32'h3000_0004);
    chk("w_dat", wbm_dat_o, 32'd10);
    chk("w_sel", {28'b0, wbm_sel_o}, 32'hF);
    tick(1);
    chk("w_cyc_hold", {31'b0, wbm_cyc_o}, 32'd1);
    wbm_ack_i = 1'b1;
    tick(1);
    wbm_ack_i = 1'b0;
    chk("w_cyc_drop", {31'b0, wbm_cyc_o}, 32'd0);
    chk("w_sel_drop", {28'b0, wbm_sel_o}, 32'd0);
    chk("w_valid", {31'b0, rsp_valid_o}, 32'd1);
    chk("w_rdata", rsp_rdata_o, 32'd0);
    chk("w_err", {31'b0, rsp_err_o}, 32'd0);
    rsp_ready = 1'b1;
    tick(1);
    rsp_ready = 1'b0;
    chk("w_valid_drop", {31'b0, rsp_valid_o}, 32'd0);
    chk("w_busy", {31'b0, busy_o}, 32'd0);

    // EXEC: opcode packing, 12-cycle wait, stray ack during WAIT ignored
    push_cmd(2'b10, 32'h0, 32'h0, 2'b10, 9'd0, 9'd100, 9'd50);
    tick(1);
    chk("x_dat", wbm_dat_o, 32'h8323_2002);
    chk("x_adr", wbm_adr_o, 32'h3000_0000);
    chk("x_we", {31'b0, wbm_we_o}, 32'd1);
    wbm_ack_i = 1'b1;
    tick(1);
    chk("x_cyc_drop", {31'b0, wbm_cyc_o}, 32'd0);
    chk("x_valid_early", {31'b0, rsp_valid_o}, 32'd0);
    tick(1);
    wbm_ack_i = 1'b0;
    tick(10);
    chk("x_valid_a11", {31'b0, rsp_valid_o}, 32'd0);
    tick(1);
    chk("x_valid_a12", {31'b0, rsp_valid_o}, 32'd1);
    chk("x_rdata", rsp_rdata_o, 32'd0);
    chk("x_err", {31'b0, rsp_err_o}, 32'd0);
    rsp_ready = 1'b1;
    tick(1);
    rsp_ready = 1'b0;

    // READ: data held while rsp_ready low, queued WRITE must not start
    push_cmd(2'b01, 32'h3000_00CC, 32'h0, 2'b00, 9'd0, 9'd0, 9'd0);
    tick(1);
    chk("r_cyc", {31'b0, wbm_cyc_o}, 32'd1);
    chk("r_we", {31'b0, wbm_we_o}, 32'd0);
    chk("r_adr", wbm_adr_o, 32'h3000_00CC);
    wbm_dat_i = 32'd30; wbm_ack_i = 1'b1;
    tick(1);
    wbm_ack_i = 1'b0; wbm_dat_i = 32'h0;
    chk("r_valid", {31'b0, rsp_valid_o}, 32'd1);
    chk("r_rdata", rsp_rdata_o, 32'd30);
    push_cmd(2'b00, 32'h3000_0010, 32'h55, 2'b00, 9'd0, 9'd0, 9'd0);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("r_hold_cyc", {31'b0, wbm_cyc_o}, 32'd0);
      chk("r_hold_rdata", rsp_rdata_o, 32'd30);
    end
    rsp_ready = 1'b1;
    tick(1);
    rsp_ready = 1'b0;
    chk("r_valid_drop", {31'b0, rsp_valid_o}, 32'd0);
    chk("r_gap_cyc", {31'b0, wbm_cyc_o}, 32'd0);
    serve("r_next", 32'h3000_0010, 1'b1, 32'h0, 32'h0);

    // FIFO full: one command parked in RESP, four queued, fifth stalls
    push_cmd(2'b00, 32'h3000_0020, 32'h66, 2'b00, 9'd0, 9'd0, 9'd0);
    wait_cyc("f_park");
    wbm_ack_i = 1'b1;
    tick(1);
    wbm_ack_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_cmd(2'b01, 32'h3000_0100 + 32'(4 * i), 32'h0, 2'b00, 9'd0, 9'd0, 9'd0);
      chk("f_ready", {31'b0, cmd_ready_o}, (i < 3) ? 32'd1 : 32'd0);
    end
    tick(3);
    chk("f_ready_stall", {31'b0, cmd_ready_o}, 32'd0);
    chk("f_cyc_stall", {31'b0, wbm_cyc_o}, 32'd0);
    chk("f_park_valid", {31'b0, rsp_valid_o}, 32'd1);
    rsp_ready = 1'b1;
    tick(1);
    rsp_ready = 1'b0;
    chk("f_park_drop", {31'b0, rsp_valid_o}, 32'd0);
    push_cmd(2'b00, 32'h3000_0200, 32'hAB, 2'b00, 9'd0, 9'd0, 9'd0);
    for (int i = 0; i < 4; i++)
      serve("f_rd", 32'h3000_0100 + 32'(4 * i), 1'b0, 32'h1000 + 32'(i), 32'h1000 + 32'(i));
    serve("f_wr", 32'h3000_0200, 1'b1, 32'h0, 32'h0);
    tick(2);
    chk("f_busy_end", {31'b0, busy_o}, 32'd0);
    chk("f_valid_end", {31'b0, rsp_valid_o}, 32'd0);

    // Timeout on READ, then queued WRITE completes cleanly
    push_cmd(2'b01, 32'h3000_0300, 32'h0, 2'b00, 9'd0, 9'd0, 9'd0);
    push_cmd(2'b00, 32'h3000_0304, 32'd7, 2'b00, 9'd0, 9'd0, 9'd0);
    chk("t_cyc", {31'b0, wbm_cyc_o}, 32'd1);
    wbm_dat_i = 32'hDEAD;
    n = 0;
    while (wbm_cyc_o && n < 100) begin tick(1); n++; end
    wbm_dat_i = 32'h0;
    chk("t_cycles", 32'(n), 32'd64);
    chk("t_valid", {31'b0, rsp_valid_o}, 32'd1);
    chk("t_err", {31'b0, rsp_err_o}, 32'd1);
    chk("t_rdata", rsp_rdata_o, 32'd0);
    rsp_ready = 1'b1;
    tick(1);
    rsp_ready = 1'b0;
    serve("t_next", 32'h3000_0304, 1'b1, 32'h0, 32'h0);

    // Ack on the terminal-count cycle is a success
    push_cmd(2'b00, 32'h3000_0308, 32'd9, 2'b00, 9'd0, 9'd0, 9'd0);
    tick(1);
    tick(63);
    chk("tc_cyc_63", {31'b0, wbm_cyc_o}, 32'd1);
    wbm_ack_i = 1'b1;
    tick(1);
    wbm_ack_i = 1'b0;
    chk("tc_valid", {31'b0, rsp_valid_o}, 32'd1);
    chk("tc_err", {31'b0, rsp_err_o}, 32'd0);
    chk("tc_cyc_drop", {31'b0, wbm_cyc_o}, 32'd0);
    rsp_ready = 1'b1;
    tick(1);
    rsp_ready = 1'b0;

    // Reset mid-BUS with two commands queued
    push_cmd(2'b01, 32'h3000_0400, 32'h0, 2'b00, 9'd0, 9'd0, 9'd0);
    push_cmd(2'b00, 32'h3000_0404, 32'd1, 2'b00, 9'd0, 9'd0, 9'd0);
    push_cmd(2'b00, 32'h3000_0408, 32'd2, 2'b00, 9'd0, 9'd0, 9'd0);
    chk("rb_cyc_before", {31'b0, wbm_cyc_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rb_cyc", {31'b0, wbm_cyc_o}, 32'd0);
    chk("rb_stb", {31'b0, wbm_stb_o}, 32'd0);
    chk("rb_ready", {31'b0, cmd_ready_o}, 32'd0);
    tick(1);
    rst_n = 1'b1;
    tick(2);
    chk("rb_ready_rel", {31'b0, cmd_ready_o}, 32'd1);
    chk("rb_busy", {31'b0, busy_o}, 32'd0);
    tick(10);
    chk("rb_cyc_later", {31'b0, wbm_cyc_o}, 32'd0);
    chk("rb_valid_later", {31'b0, rsp_valid_o}, 32'd0);
    chk("rb_busy_later", {31'b0, busy_o}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wb_fhe_host_master.md
Name: wb_fhe_host_master

Overview:
- Wishbone classic-cycle initiator that drives the FHE accelerator's slave port (user_project_wrapper) from a simple command stream. It is the initiating end of that slave interface.
- Used by the on-chip host sequencer and by integration benches as a reusable bus driver. Supports three command kinds:
  - single-word writes (ciphertext/key loads);
  - single-word reads (result fetch);
  - EXEC, which packs an FHE opcode word and writes it to OPCODE_ADDR.
- Commands are buffered in a small FIFO. Exactly one response is returned per command.

Parameters:
- ADDR_WIDTH, 9: width of src_a/src_b/dst operand-address fields in the opcode word.
- OPCODE_ADDR, 32'h30000000: bus address EXEC writes to.
- FIFO_DEPTH, 4: command FIFO entries; power of 2, ≥2.
- TIMEOUT, 64: max cycles waiting for wbm_ack_i before abort; ≥1.
- EXEC_WAIT, 12: idle cycles after an EXEC ack before its response (accelerator compute time).

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_ni  in  1  reset; one clock, reset asynchronous, active-low.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  FIFO not full.
- cmd_kind_i  in  2  00 WRITE, 01 READ, 10 EXEC, 11 reserved (treated as READ).
- cmd_addr_i  in  32  byte address for WRITE/READ.
- cmd_wdata_i  in  32  WRITE data.
- cmd_fhe_op_i  in  2  EXEC op: 00 enc, 01 dec, 10 add, 11 mul.
- cmd_src_a_i  in  ADDR_WIDTH  EXEC operand A.
- cmd_src_b_i  in  ADDR_WIDTH  EXEC operand B.
- cmd_dst_i  in  ADDR_WIDTH  EXEC destination.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response accepted.
- rsp_rdata_o  out  32  read data; 0 for WRITE/EXEC or on error.
- rsp_err_o  out  1  timeout occurred.
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1  Wishbone controls.
- wbm_sel_o  out  4  byte selects; always 4'b1111 while cyc is high, 0 otherwise.
- wbm_adr_o  out  32  address.
- wbm_dat_o  out  32  write data.
- wbm_dat_i  in  32  read data.
- wbm_ack_i  in  1  slave ack.
- busy_o  out  1  FSM not IDLE or FIFO not empty.

Behaviour:
- Reset (async assert, sync release): FIFO empty; FSM IDLE.
  - All wbm_* outputs 0; rsp_valid_o, rsp_err_o 0; rsp_rdata_o 0.
  - cmd_ready_o is 0 while reset is asserted and 1 after release.
- FIFO:
  - Push on cmd_valid_i & cmd_ready_o.
  - cmd_ready_o = !full, registered from occupancy. Pop in the same cycle does not raise ready.
  - Pointers wrap modulo FIFO_DEPTH.
  - Stores kind, addr, wdata, and the EXEC word, packed at push time.
- EXEC word packing:
  - [1:0] = op
  - [ADDR_WIDTH+1:2] = src_a
  - [2*ADDR_WIDTH+1:ADDR_WIDTH+2] = src_b
  - [3*ADDR_WIDTH+1:2*ADDR_WIDTH+2] = dst
  - bit 31 = 1; all other bits 0.
  - EXEC drives addr = OPCODE_ADDR and we = 1.
- FSM states: IDLE, BUS, WAIT, RESP.
  - IDLE: if FIFO is non-empty, pop and go to BUS. The cyc, stb, we, adr and dat outputs are registered on that edge.
    - Latency: a command pushed at edge E into an empty FIFO in IDLE has cyc high after edge E+1.
  - BUS: cyc, stb and sel held constant; timeout counter increments each cycle.
    - ack sampled at edge A: cyc, stb, we, sel drop after A. READ captures wbm_dat_i into rsp_rdata_o.
      - READ/WRITE go to RESP with rsp_valid_o high after A.
      - EXEC goes to WAIT.
    - Timeout: counter reaches TIMEOUT with no ack. Bus is dropped, rsp_err_o = 1, rdata = 0, go to RESP. An EXEC that times out skips WAIT.
  - WAIT: counts EXEC_WAIT cycles, then RESP. rsp_valid_o rises EXEC_WAIT cycles after A.
  - RESP: rsp_valid_o held, with data and err stable, until rsp_ready_i. On the handshake edge rsp_valid_o drops and the FSM returns to IDLE.
    - No new bus cycle starts before the handshake completes; back-to-back commands therefore have at least 1 idle bus cycle.
- Other rules:
  - wbm_ack_i outside BUS is ignored.
  - An ack in the same cycle as the timeout terminal count counts as success.
  - Reset mid-transaction: cyc and stb drop immediately (async). Pending FIFO entries and the response are discarded.

Test Plan:
- Reset, then push WRITE addr=0x30000004 data=10. Required: cyc/stb/we high after acceptance edge+1, adr=0x30000004, dat=10, sel=4'hF. Ack after 2 cycles → rsp_valid_o=1, rdata=0, err=0.
- EXEC op=10, src_a=0, src_b=100, dst=50. Required: wbm_dat_o=0x83232002, adr=0x30000000. rsp_valid_o rises exactly 12 cycles after ack.
- READ addr=0x300000CC, slave acks with wbm_dat_i=30. Required: rsp_rdata_o=30 held until rsp_ready_i; with rsp_ready_i low for 5 cycles, no second bus cycle starts.
- Push 5 commands back-to-back with the slave stalled. Required: cmd_ready_o low after the 4th push; entries issue in order and each returns one response.
- READ with the slave never acking, TIMEOUT=64. Required: cyc drops after 64 cycles, rsp_err_o=1, rdata=0. The next queued WRITE then completes normally with err=0.
- Assert wb_rst_ni low mid-BUS with 2 commands queued. Required: cyc/stb 0 immediately; after release cmd_ready_o=1, busy_o=0, no response issued.
